// File: rtl/prio_arbiter_4ch.sv
// prio_arbiter_4ch: four-requester fixed-priority arbiter with a locked grant.
// req[3] has the highest priority. A grant is registered and held until the
// owner drops its request. There is no preemption.
// Optional feature macro: PRIO_ARB_TIMEOUT_EN. When it is defined, a grant is
// forcibly revoked after MAX_HOLD cycles. The revoked requester is then masked
// until it drops its request.
// Handshake: req[i] is a level request. gnt[i] is the grant for the same
// requester. The owner keeps the resource while req[i] stays high. The owner
// gives it up by deasserting req[i]. After every release or revoke there is
// one idle bubble cycle before the next owner is granted.
module prio_arbiter_4ch #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       dbg_state
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    // Reject parameter sets whose counter could not hold MAX_HOLD-1.
    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_param_check
        $error("prio_arbiter_4ch: illegal MAX_HOLD/CNT_W combination");
    end

    logic       state;
    logic       state_nxt;
    logic [3:0] mask;
    logic [3:0] eff_req;
    logic [1:0] win_id;
    logic       win_valid;
    logic       owner_req;
    logic       hold_limit;
    logic [3:0] gnt_nxt;
    logic [1:0] gnt_id_nxt;
    logic       gnt_valid_nxt;
    logic       timeout_nxt;

    assign eff_req   = req & ~mask;
    assign owner_req = req[gnt_id];
    assign dbg_state = state;

`ifdef PRIO_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             revoke;

    assign hold_limit = (hold_cnt == HOLD_LAST);
    assign revoke     = (state == ST_GRANT) && owner_req && hold_limit;

    // Hold counter: counts grant cycles and restarts from 0 on every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == ST_GRANT && state_nxt == ST_GRANT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Mask: a revoked owner is blocked until its request line goes low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= 4'b0000;
        end else begin
            mask <= (mask & req) | (revoke ? (4'b0001 << gnt_id) : 4'b0000);
        end
    end
`else
    assign mask       = 4'b0000;
    assign hold_limit = 1'b0;
`endif

    // Fixed-priority pick over unmasked requests; the highest index wins.
    always_comb begin
        win_valid = |eff_req;
        win_id    = 2'd0;
        if (eff_req[3]) begin
            win_id = 2'd3;
        end else if (eff_req[2]) begin
            win_id = 2'd2;
        end else if (eff_req[1]) begin
            win_id = 2'd1;
        end
    end

    // Next-state logic: grant from IDLE, then hold until release or revoke.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_nxt     = ST_GRANT;
                    gnt_nxt       = 4'b0001 << win_id;
                    gnt_id_nxt    = win_id;
                    gnt_valid_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                // A normal release takes precedence over the hold limit.
                if (!owner_req || hold_limit) begin
                    state_nxt     = ST_IDLE;
                    gnt_nxt       = 4'b0000;
                    gnt_id_nxt    = 2'd0;
                    gnt_valid_nxt = 1'b0;
                    timeout_nxt   = owner_req;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                gnt_nxt       = 4'b0000;
                gnt_id_nxt    = 2'd0;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // Registered state and grant outputs; reset clears any grant in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_prio_arbiter_4ch.sv
// Testbench for prio_arbiter_4ch: directed steps followed by a random phase,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_prio_arbiter_4ch;

    localparam int MAX_HOLD = 8;
`ifdef PRIO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic       dbg_state;

    int n_cmp;
    int n_err;

    // Reference model state: current owner (-1 when nobody holds the resource),
    // cycles held so far, blocked requesters, and the expected timeout pulse.
    int         m_owner;
    int         m_held;
    logic [3:0] m_blocked;
    logic       m_timeout;

    prio_arbiter_4ch #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_blocked = 4'b0000;
        m_timeout = 1'b0;
    endtask

    // Applies the arbitration rules for one clock edge that samples request r.
    task automatic model_step(input logic [3:0] r);
        logic [3:0] nb;
        nb        = m_blocked & r;
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            for (int i = 3; i >= 0; i--) begin
                if (m_owner < 0 && r[i] && !m_blocked[i]) begin
                    m_owner = i;
                    m_held  = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_held == MAX_HOLD) begin
            m_timeout     = 1'b1;
            nb[m_owner]   = 1'b1;
            m_owner       = -1;
        end else begin
            m_held++;
        end
        m_blocked = nb;
    endtask

    // Scoreboard check of all DUT outputs against the model.
    task automatic check(input string tag);
        logic [3:0] eg;
        logic [1:0] eid;
        logic       ev;
        eg  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        ev  = (m_owner >= 0);
        n_cmp++;
        assert (gnt === eg) else begin
            n_err++;
            $error("FAIL %s gnt: got %b expected %b", tag, gnt, eg);
        end
        n_cmp++;
        assert (gnt_id === eid) else begin
            n_err++;
            $error("FAIL %s gnt_id: got %0d expected %0d", tag, gnt_id, eid);
        end
        n_cmp++;
        assert (gnt_valid === ev) else begin
            n_err++;
            $error("FAIL %s gnt_valid: got %b expected %b", tag, gnt_valid, ev);
        end
        n_cmp++;
        assert (timeout === m_timeout) else begin
            n_err++;
            $error("FAIL %s timeout: got %b expected %b", tag, timeout, m_timeout);
        end
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] lit);
        n_cmp++;
        assert (gnt === lit) else begin
            n_err++;
            $error("FAIL %s gnt_literal: got %b expected %b", tag, gnt, lit);
        end
    endtask

    task automatic expect_to(input string tag, input logic lit);
        n_cmp++;
        assert (timeout === lit) else begin
            n_err++;
            $error("FAIL %s timeout_literal: got %b expected %b", tag, timeout, lit);
        end
    endtask

    // Driver: present r for one clock edge, advance the model, check at negedge.
    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        logic [3:0] r;
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        req   = 4'b1111;

        // 1: reset with all requests high, then first grant goes to req[3]
        repeat (3) @(negedge clk);
        check("reset");
        expect_gnt("reset", 4'b0000);
        rst_n = 1'b1;
        cycle(4'b1111, "first_grant");
        expect_gnt("first_grant", 4'b1000);
        cycle(4'b0000, "release3");

        // 2: priority pick, then one bubble, then next owner
        cycle(4'b0101, "pick2");
        expect_gnt("pick2", 4'b0100);
        cycle(4'b0001, "bubble2");
        expect_gnt("bubble2", 4'b0000);
        cycle(4'b0001, "pick0");
        expect_gnt("pick0", 4'b0001);

        // 3: lock, a higher request does not preempt the owner
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1001, "lock");
            expect_gnt("lock", 4'b0001);
        end
        cycle(4'b1000, "lock_bubble");
        expect_gnt("lock_bubble", 4'b0000);
        cycle(4'b1000, "lock_next");
        expect_gnt("lock_next", 4'b1000);
        cycle(4'b0000, "idle3");

        // 4: long hold of 1010 (forced release when the timeout is built in)
        for (int i = 1; i <= 20; i++) begin
            cycle(4'b1010, "hold1010");
`ifdef PRIO_ARB_TIMEOUT_EN
            if (i <= 8) expect_gnt("to_hold", 4'b1000);
            if (i == 9) begin
                expect_gnt("to_revoke", 4'b0000);
                expect_to("to_revoke", 1'b1);
            end
            if (i == 10) expect_gnt("to_next", 4'b0010);
`else
            expect_gnt("nolimit_hold", 4'b1000);
            expect_to("nolimit_hold", 1'b0);
`endif
        end
        cycle(4'b0010, "drop3");
        cycle(4'b1010, "regain3");
        expect_gnt("regain3", 4'b1000);
        cycle(4'b1000, "keep3");
        cycle(4'b0000, "idle4");

        // Owner drops on the same edge the hold limit is reached
        for (int i = 0; i < MAX_HOLD; i++) cycle(4'b0100, "sim_hold");
        cycle(4'b0000, "sim_drop");
        expect_to("sim_drop", 1'b0);
        cycle(4'b0100, "sim_regrant");
        expect_gnt("sim_regrant", 4'b0100);
        cycle(4'b0000, "idle_sim");

        // 5: single requester held for 50 cycles
        for (int i = 0; i < 50; i++) begin
            cycle(4'b0001, "hold50");
`ifndef PRIO_ARB_TIMEOUT_EN
            expect_gnt("hold50", 4'b0001);
            expect_to("hold50", 1'b0);
`endif
        end
        cycle(4'b0000, "idle5");

        // 6: asynchronous reset in the middle of a grant
        for (int i = 0; i < 12; i++) cycle(4'b0011, "pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst");
        expect_gnt("async_rst", 4'b0000);
        @(negedge clk);
        check("rst_hold");
        rst_n = 1'b1;
        cycle(4'b0011, "post_rst");
        expect_gnt("post_rst", 4'b0010);

        // Random phase: requests mostly held, changed occasionally
        r = 4'b0011;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            cycle(r, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_4ch.md
# prio_arbiter_4ch

- Four-requester arbiter with fixed priority that shares one downstream resource.
- Grant encoding follows the team's 4-to-2 priority-encoder convention: `req[3]` is highest priority and the winner is reported as a 2-bit index plus a valid flag.
- Unlike the encoder, it is sequential: a grant is registered and held (locked) until the owner releases it. An optional hold-timeout stops one requester from starving the others.
- Sits between the requesting units and the shared resource's select mux.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before forced release. Legal range 2..255.
- `CNT_W`, default 8: width of the hold counter. Must satisfy 2^`CNT_W` > `MAX_HOLD`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low; the block's only reset.
- `req`  in  4  request lines; `req[i]` is held high for as long as requester i wants the resource.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `gnt_id`  out  2  binary index of the current owner; 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  high whenever `gnt` is non-zero.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation

State machine:
- **IDLE**
  - Arbitrates over `eff_req = req & ~mask`. Highest set index wins.
  - If `eff_req`≠0: load the owner, set `gnt`/`gnt_id`/`gnt_valid`, clear `hold_cnt` to 0, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `hold_cnt` increments every cycle.
  - If `req[owner]`=0: clear all grant outputs, go to IDLE.
  - Else if the timeout feature is present and `hold_cnt`==`MAX_HOLD`-1: clear grant outputs, pulse `timeout`, set `mask[owner]`, go to IDLE.
  - Otherwise hold all outputs.
- Lock rule: while in GRANT, higher-priority requests are ignored. There is no preemption.
- `mask[i]` clears on any cycle in which `req[i]`=0. A requester that is cut off must drop its request before it can win again.
- `gnt` is always one-hot or zero; `gnt_id` is always consistent with `gnt`.
- Invariant: `gnt` is never non-zero for a requester whose `mask` bit is set.

## Timing

Reset:
- `rst_n` low immediately (asynchronously) forces `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, `mask`=0, `hold_cnt`=0, state=IDLE.
- Applies mid-grant too. No partial grant survives reset.

Latencies:
- Grant latency: `req` sampled at edge N → `gnt` high after edge N.
- Release: `req[owner]` low sampled at edge N → `gnt`=0 after edge N. The earliest new grant is after edge N+1, so there is exactly one bubble cycle between owners.
- Timeout: a grant lasts exactly `MAX_HOLD` cycles. `timeout` is high for the single cycle after the revoking edge, aligned with `gnt`=0.

Simultaneous events:
- Owner drops at the same edge the counter hits the limit: normal release wins. No `timeout` pulse, no mask set.
- New requests arriving during the bubble cycle are all considered at the next IDLE edge.
- The counter never wraps, because the maximum value reached is `MAX_HOLD`-1.

## Configuration

`PRIO_ARB_TIMEOUT_EN`:
- **Defined:** the hold counter, the `mask` register and forced release are present, as described above.
- **Undefined:**
  - A grant is held for as long as the owner's request stays high, with no limit.
  - `timeout` is tied to 0 and `mask` is constant 0.
  - The counter logic is omitted.
  - All other behaviour is identical.

## Test plan

1. Assert `rst_n`=0 at time 0, with `req`=4'b1111 applied during reset → all outputs 0. Release reset → first grant `gnt`=4'b1000, `gnt_id`=3.
2. `req`=4'b0101 → `gnt`=4'b0100, `gnt_id`=2. Drop `req[2]` → one cycle with `gnt`=0, then `gnt`=4'b0001, `gnt_id`=0.
3. Lock: while `gnt`=4'b0001, raise `req[3]` for 5 cycles → `gnt` stays 4'b0001. Drop `req[0]` → bubble, then `gnt`=4'b1000.
4. Timeout (macro defined, `MAX_HOLD`=8): hold `req`=4'b1010 for 20 cycles.
   - `gnt`=4'b1000 for exactly 8 cycles, then `timeout` pulses once and `gnt`=0 for one cycle.
   - Then `gnt`=4'b0010, even though `req[3]` is still high.
   - Drop `req[3]` for one cycle, reassert it, release `req[1]` → `gnt`=4'b1000 again.
5. Macro undefined: `req`=4'b0001 held 50 cycles → `gnt`=4'b0001 for all 50 cycles and `timeout` never asserts.
6. Assert `rst_n` asynchronously mid-cycle during a grant → outputs clear before the next clock edge. After release of reset, a masked requester is granted normally.
